// File: rtl/z80_mbox_pkg.sv
// Shared constants for the Z80 I/O mailbox: register offsets, STATUS bit
// positions, data-bus direction values and the decoded-address record.
package z80_mbox_pkg;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_RXLVL  = 2'd2;
  localparam logic [1:0] OFS_TXLVL  = 2'd3;

  localparam int ST_RX_NE   = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_RX_UNF  = 2;
  localparam int ST_TX_OVF  = 3;
  localparam int ST_IE      = 7;

  // Level-shifter direction: D_OUT drives the FPGA byte onto the Z80 bus.
  localparam logic D_IN  = 1'b0;
  localparam logic D_OUT = 1'b1;

  typedef struct packed {
    logic       hit;
    logic [1:0] ofs;
  } decode_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with show-ahead head, occupancy level and
// simultaneous push/pop support at both the full and empty boundaries.
module sync_byte_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  // When full, a same-cycle pop frees the slot the push lands in; when empty,
  // the pop has nothing to take even though the push succeeds.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/z80_io_mailbox_fifo.sv
// Z80 I/O-mapped mailbox: TX/RX byte FIFOs between the Z80 bus and the SPI
// sequencer streams, with STATUS/level registers and sticky error flags.
module z80_io_mailbox_fifo
  import z80_mbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h3039,
  parameter int          ADDR_STRIDE = 2,
  parameter int          FIFO_DEPTH  = 8,
  parameter bit          DECODE_FULL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] z80_a,
  input  logic [7:0]  z80_d_in,
  output logic [7:0]  z80_d_out,
  output logic        z80_d_oe,
  input  logic        z80_rd,
  input  logic        z80_wr,
  input  logic        z80_iorq,
  input  logic        z80_m1,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq_n
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  function automatic decode_t decode(input logic [15:0] a);
    decode_t     r;
    logic [15:0] ra;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      ra = BASE_ADDR + 16'(k * ADDR_STRIDE);
      if (DECODE_FULL ? (a == ra) : (a[7:0] == ra[7:0])) begin
        r.hit = 1'b1;
        r.ofs = 2'(k);
      end
    end
    return r;
  endfunction

  // Levels wider than a byte (DEPTH=256) wrap to 0 on the register window.
  function automatic logic [7:0] lvl8(input logic [LW-1:0] l);
    return 8'(l);
  endfunction

  // Read enable comes straight from the pins so the Z80 sees data in-cycle.
  decode_t dec_raw;
  logic    oe_raw;

  assign dec_raw   = decode(z80_a);
  assign oe_raw    = ~z80_iorq & z80_m1 & dec_raw.hit & ~z80_rd & z80_wr & ~rst;
  assign z80_d_oe  = oe_raw ? D_OUT : D_IN;

  // Strobe synchronisers; address, data and M1 ride along stage for stage.
  logic [1:0]  wr_sync, rd_sync, iorq_sync;
  logic [15:0] a_s1, a_s2;
  logic [7:0]  d_s1, d_s2;
  logic        m1_s1, m1_s2;
  logic [1:0]  settle;
  logic        wr_prev, rd_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sync   <= 2'b11;
      rd_sync   <= 2'b11;
      iorq_sync <= 2'b11;
      a_s1      <= '0;
      a_s2      <= '0;
      d_s1      <= '0;
      d_s2      <= '0;
      m1_s1     <= 1'b1;
      m1_s2     <= 1'b1;
      settle    <= '0;
      wr_prev   <= 1'b0;
      rd_prev   <= 1'b0;
    end else begin
      wr_sync   <= {wr_sync[0], z80_wr};
      rd_sync   <= {rd_sync[0], z80_rd};
      iorq_sync <= {iorq_sync[0], z80_iorq};
      a_s1      <= z80_a;
      a_s2      <= a_s1;
      d_s1      <= z80_d_in;
      d_s2      <= d_s1;
      m1_s1     <= z80_m1;
      m1_s2     <= m1_s1;
      settle    <= {settle[0], 1'b1};
      // prev only holds post-reset pin samples, so a strobe held low across
      // reset must be seen high before its falling edge counts.
      wr_prev   <= settle[1] & wr_sync[1];
      rd_prev   <= settle[1] & rd_sync[1];
    end
  end

  decode_t dec_s;
  logic    hit_s, wr_fall, rd_fall, rd_rise, wr_act, st_wr;

  assign dec_s   = decode(a_s2);
  assign hit_s   = ~iorq_sync[1] & m1_s2 & dec_s.hit;
  assign wr_fall = wr_prev & ~wr_sync[1];
  assign rd_fall = rd_prev & ~rd_sync[1];
  assign rd_rise = ~rd_prev & rd_sync[1];
  assign wr_act  = wr_fall & hit_s;
  assign st_wr   = wr_act & (dec_s.ofs == OFS_STATUS);

  // Streams: a byte moves on a clk edge where valid & ready are both high;
  // valid never depends on ready and the offered byte is held until taken.
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_dout;
  logic [LW-1:0] tx_level, rx_level;
  logic          rd_pend, rx_unf, tx_ovf, ie;

  assign tx_push = wr_act & (dec_s.ofs == OFS_DATA);
  assign tx_pop  = tx_valid & tx_ready;
  assign rx_push = rx_valid & rx_ready;
  assign rx_pop  = rd_rise & rd_pend;

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (d_s2),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign irq_n    = ~(~rx_empty & ie);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rx_unf  <= 1'b0;
      tx_ovf  <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (rd_fall && hit_s && dec_s.ofs == OFS_DATA) rd_pend <= 1'b1;
      else if (rd_rise)                              rd_pend <= 1'b0;
      // Sticky flags: a set in the same clk as a W1C clear wins.
      rx_unf <= (rx_pop & rx_empty) | (rx_unf & ~(st_wr & d_s2[ST_RX_UNF]));
      tx_ovf <= (tx_push & tx_full & ~tx_pop) | (tx_ovf & ~(st_wr & d_s2[ST_TX_OVF]));
      if (st_wr) ie <= d_s2[ST_IE];
    end
  end

  logic [7:0] status_byte;
  logic [7:0] d_out_mux;

  always_comb begin
    status_byte             = '0;
    status_byte[ST_RX_NE]   = ~rx_empty;
    status_byte[ST_TX_FULL] = tx_full;
    status_byte[ST_RX_UNF]  = rx_unf;
    status_byte[ST_TX_OVF]  = tx_ovf;
    status_byte[ST_IE]      = ie;
  end

  always_comb begin
    d_out_mux = 8'hFF;
    if (oe_raw) begin
      case (dec_raw.ofs)
        OFS_DATA:   d_out_mux = rx_empty ? 8'hFF : rx_dout;
        OFS_STATUS: d_out_mux = status_byte;
        OFS_RXLVL:  d_out_mux = lvl8(rx_level);
        OFS_TXLVL:  d_out_mux = lvl8(tx_level);
        default:    d_out_mux = 8'hFF;
      endcase
    end
  end

  assign z80_d_out = d_out_mux;

endmodule
